// File: rtl/dp_pkg.sv
// dp_pkg: shared types and constants for the dot-product engine.
//   dp_state_t  - sequencer states (IDLE, RD, ACC, OUT)
//   acc_width() - accumulator width that cannot overflow for a given
//                 element width and maximum vector length
//   WR_SEL_ROW / WR_SEL_COL - wr_sel encodings for the shared write port
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } dp_state_t;

  localparam logic WR_SEL_ROW = 1'b0;
  localparam logic WR_SEL_COL = 1'b1;

  // Full product needs 2*in_w bits; summing depth of them adds clog2(depth)
  // bits, plus one so the all-negative-squared worst case stays positive.
  function automatic int acc_width(input int in_w, input int depth);
    return 2 * in_w + $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dp_mac.sv
// dp_mac: signed multiply-accumulate.
//   clk, rst  - clock, synchronous active-high reset (clears acc)
//   clr       - clear accumulator (priority over en)
//   en        - add a*b (full precision, sign-extended) to acc
//   a, b      - signed IN_W operands
//   acc       - signed ACC_W running sum
module dp_mac
  import dp_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = acc_width(8, 16)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*IN_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-2*IN_W){prod[2*IN_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: row/column vector buffers plus a self-sequenced
// signed dot product with a valid/ready result handshake.
//   clk, rst            - clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data - shared buffer write port (sel 0=row, 1=col)
//   wr_reject           - one-cycle pulse after a write dropped while busy
//   start, len          - launch a run of len elements (clamped to DEPTH)
//   busy                - run in progress (start and writes refused)
//   out_valid/out_ready - result handshake; y is held while stalled
//   y                   - signed ACC_W dot product
// Build option: define DOT_PRODUCT_RELU_EN to clip negative results to 0.
module dot_product_engine
  import dp_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ACC_W  = acc_width(IN_W, DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic signed [IN_W-1:0]  wr_data,
  output logic                    wr_reject,
  input  logic                    start,
  input  logic [ADDR_W:0]         len,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] y
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  function automatic logic signed [ACC_W-1:0] relu_clip(input logic signed [ACC_W-1:0] v);
`ifdef DOT_PRODUCT_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  logic signed [IN_W-1:0]  row_mem [DEPTH];
  logic signed [IN_W-1:0]  col_mem [DEPTH];

  dp_state_t               state, state_n;
  logic [ADDR_W:0]         cnt_len;
  logic [ADDR_W:0]         addr;
  logic                    rd_en, mac_clr, load_out, clear_out;
  logic signed [IN_W-1:0]  row_p1, col_p1;
  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_p2;

  assign busy = (state != IDLE);

  // addr doubles as the count of reads issued; once it reaches cnt_len the
  // product of the last read is being accumulated this cycle.
  always_comb begin
    state_n   = state;
    rd_en     = 1'b0;
    mac_clr   = 1'b0;
    load_out  = 1'b0;
    clear_out = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mac_clr = 1'b1;
          state_n = RD;
        end
      end
      RD: begin
        if (cnt_len == '0) begin
          state_n = OUT;
        end else begin
          rd_en   = 1'b1;
          state_n = ACC;
        end
      end
      ACC: begin
        if (addr == cnt_len) begin
          state_n = OUT;
        end else begin
          rd_en = 1'b1;
        end
      end
      OUT: begin
        if (!out_valid) begin
          load_out = 1'b1;
        end else if (out_ready) begin
          clear_out = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_len   <= '0;
      addr      <= '0;
      vld_p1    <= 1'b0;
      wr_reject <= 1'b0;
    end else begin
      state     <= state_n;
      vld_p1    <= rd_en;
      wr_reject <= wr_en && busy;
      if (mac_clr) begin
        cnt_len <= clamp_len(len);
        addr    <= '0;
      end else if (rd_en) begin
        addr <= addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      if (wr_sel == WR_SEL_ROW) begin
        row_mem[wr_addr] <= wr_data;
      end else begin
        col_mem[wr_addr] <= wr_data;
      end
    end
  end

  // ---- stage p1: synchronous buffer read ----
  always_ff @(posedge clk) begin
    if (rd_en) begin
      row_p1 <= row_mem[addr[ADDR_W-1:0]];
      col_p1 <= col_mem[addr[ADDR_W-1:0]];
    end
  end

  // ---- stage p2: multiply-accumulate ----
  dp_mac #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (vld_p1),
    .a   (row_p1),
    .b   (col_p1),
    .acc (acc_p2)
  );

  // ---- output stage: result register held until handshake ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      y         <= relu_clip(acc_p2);
    end else if (clear_out) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine: directed cases plus randomized
// runs compared against an array-based dot-product model with len clamping.
module tb_dot_product_engine;
  import dp_pkg::*;

  localparam int IN_W   = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int ACC_W  = acc_width(IN_W, DEPTH);

  logic                    clk, rst;
  logic                    wr_en, wr_sel;
  logic [ADDR_W-1:0]       wr_addr;
  logic signed [IN_W-1:0]  wr_data;
  logic                    wr_reject;
  logic                    start;
  logic [ADDR_W:0]         len;
  logic                    busy, out_valid, out_ready;
  logic signed [ACC_W-1:0] y;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int row_m [DEPTH];
  int col_m [DEPTH];

  dot_product_engine #(
    .IN_W   (IN_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_reject (wr_reject),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int ln);
    return (ln > DEPTH) ? DEPTH : ln;
  endfunction

  function automatic longint model(input int ln);
    longint s = 0;
    for (int i = 0; i < eff_len(ln); i++) s += longint'(row_m[i]) * longint'(col_m[i]);
`ifdef DOT_PRODUCT_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Idle-time write; the model tracks it.
  task automatic wr(input logic sel, input int a, input int d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = ADDR_W'(a); wr_data = IN_W'(d);
    tick();
    wr_en = 1'b0;
    if (sel == WR_SEL_COL) col_m[a] = d; else row_m[a] = d;
  endtask

  function automatic int rnd_elem();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic start_run(input int ln, input int hold);
    out_ready = (hold == 0);
    len = (ADDR_W+1)'(ln);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk("busy_on_start", busy, 1);
  endtask

  task automatic finish_run(input string tag, input int ln, input int hold);
    longint e = model(ln);
    int k = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, cyc - t0, eff_len(ln) + 2);
    chk({tag, "_y"}, y, e);
    if (hold == 0) begin
      tick();
      chk({tag, "_valid_pulse"}, out_valid, 0);
      chk({tag, "_busy_release"}, busy, 0);
    end else begin
      for (int h = 0; h < hold; h++) begin
        start = 1'b1;
        len = (ADDR_W+1)'($urandom_range(0, 20));
        tick();
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_y"}, y, e);
        chk({tag, "_hold_busy"}, busy, 1);
      end
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      chk({tag, "_hs_valid"}, out_valid, 0);
      chk({tag, "_hs_busy"}, busy, 0);
    end
  endtask

  initial begin
    int seen;
    int d;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_reject", wr_reject, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      wr(WR_SEL_ROW, i, 0);
      wr(WR_SEL_COL, i, 0);
    end

    // Basic vector
    for (int i = 0; i < 4; i++) begin
      wr(WR_SEL_ROW, i, i + 1);
      wr(WR_SEL_COL, i, i + 5);
    end
    chk("idle_write_no_reject", wr_reject, 0);
    start_run(4, 0);
    finish_run("basic", 4, 0);

    // Extremes
    for (int i = 0; i < DEPTH; i++) begin
      wr(WR_SEL_ROW, i, -128);
      wr(WR_SEL_COL, i, -128);
    end
    start_run(16, 0);
    finish_run("max_pos", 16, 0);
    for (int i = 0; i < DEPTH; i++) wr(WR_SEL_COL, i, 127);
    start_run(16, 0);
    finish_run("max_neg", 16, 0);

    // Zero length and clamped length
    start_run(0, 0);
    finish_run("len0", 0, 0);
    start_run(20, 0);
    finish_run("len20", 20, 0);

    // Back-pressure with ignored start pulses, then a fresh start
    for (int i = 0; i < DEPTH; i++) begin
      wr(WR_SEL_ROW, i, rnd_elem());
      wr(WR_SEL_COL, i, rnd_elem());
    end
    start_run(7, 5);
    finish_run("stall", 7, 5);
    start_run(3, 0);
    finish_run("after_stall", 3, 0);

    // Write while busy is dropped
    start_run(8, 0);
    d = (row_m[0] == 5) ? 6 : 5;
    wr_en = 1'b1; wr_sel = WR_SEL_ROW; wr_addr = '0; wr_data = IN_W'(d);
    tick();
    wr_en = 1'b0;
    chk("reject_pulse", wr_reject, 1);
    tick();
    chk("reject_clear", wr_reject, 0);
    finish_run("reject_run", 8, 0);
    start_run(8, 0);
    finish_run("reject_rerun", 8, 0);

    // Start and write in the same idle cycle: the run sees the new data
    len = 5'd3; start = 1'b1; out_ready = 1'b1;
    wr_en = 1'b1; wr_sel = WR_SEL_ROW; wr_addr = '0; wr_data = 8'sd10;
    tick();
    row_m[0] = 10;
    start = 1'b0; wr_en = 1'b0;
    t0 = cyc;
    chk("same_cycle_busy", busy, 1);
    finish_run("same_cycle", 3, 0);

    // Reset in the middle of accumulation
    start_run(10, 0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    start_run(5, 0);
    finish_run("after_rst", 5, 0);

    // Randomized runs
    for (int it = 0; it < 12; it++) begin
      int nw = int'($urandom_range(0, 6));
      int ln = int'($urandom_range(0, 20));
      int hold = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) wr(logic'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), rnd_elem());
      start_run(ln, hold);
      finish_run("rand", ln, hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
